vga_timing_engine: RTL and testbench
====================================

// Module: vga_timing_engine
// PURPOSE
//  Parametrised VGA timing generator: pixel-enable divider, H/V counters, latency-compensated sync/blank pipeline.
//  Emits request coordinates to the slot/panel renderers and takes back their RGB after a fixed latency.
//  Game-state channels (money, reel states) are latched once per frame so reel and digit graphics never tear mid-frame.
//  Sits between the 50 MHz core clock domain logic and the VGA DAC pins.
// PARAMETERS
//  H_VA 640 visible px | H_FP 16 | H_SYNC 96 | H_BP 48 (H_TOTAL = sum, must be <= 1024)
//  V_VA 480 visible lines | V_FP 10 | V_SYNC 2 | V_BP 33 (V_TOTAL = sum, must be <= 1024)
//  HS_POL 0, VS_POL 0: sync active level (0 = active-low)
//  CLK_DIV 2: clk cycles per pixel (>= 1; 1 = pix_en always high)
//  LAT 2: renderer latency in pixel ticks (>= 1)
//  NUM_CH 4, DATA_W 10: count and width of frame-latched state channels
// PORTS
//  clk        in  1  core clock
//  rst        in  1  asynchronous reset, active-low
//  stop       in  1  freeze scan at the next frame boundary
//  test_mode  in  1  colour-bar select (only with VGA_TESTPAT_EN)
//  rgb_in     in  24 renderer colour {R,G,B} for the coordinate issued LAT ticks earlier
//  ch_in      in  NUM_CH*DATA_W  live state channels
//  x, y       out 10 request coordinate (hcnt, vcnt)
//  req_active out 1  x < H_VA && y < V_VA
//  pix_en     out 1  pixel tick strobe
//  hs, vs     out 1  syncs, latency-aligned with R/G/B
//  blank_n    out 1  1 = visible pixel, aligned with R/G/B
//  sync_n     out 1  constant 1
//  R, G, B    out 8 each  registered colour; 0 when blanked
//  frame_start out 1 one-clk pulse on frame wrap
//  frame_cnt  out 16 frames completed, wraps
//  ch_shadow  out NUM_CH*DATA_W  channels latched at frame_start
// BEHAVIOUR
//  Reset (async, rst=0): div/hcnt/vcnt=0, hs=~HS_POL, vs=~VS_POL, blank_n=0, RGB=0, frame_start=0,
//   frame_cnt=0, ch_shadow=0, pipeline cleared to inactive. Reset mid-frame clears immediately; scan restarts at (0,0).
//  Divider: div counts 0..CLK_DIV-1; pix_en=1 in the clk where div==CLK_DIV-1. All counters and pipeline advance only on pix_en.
//  Counters: hcnt 0..H_TOTAL-1 then 0 with vcnt+1; vcnt wraps V_TOTAL-1 -> 0. No out-of-range values ever.
//  States: RUN, HOLD. RUN->HOLD when stop=1 on the pix_en that wraps (H_TOTAL-1,V_TOTAL-1)->(0,0); counters hold at (0,0).
//   HOLD->RUN on the first pix_en with stop=0. stop asserted mid-frame has no effect until the frame ends.
//  Raw sync: hs_raw active for H_VA+H_FP <= hcnt < H_VA+H_FP+H_SYNC; vs_raw same with V_*. active_raw = req_active (strict <).
//  Pipeline: {hs_raw,vs_raw,active_raw} delayed LAT pix_en ticks; on tick LAT, hs/vs/blank_n update and
//   RGB <= active ? rgb_in : 0. All outputs registered; x/y issued at tick t appear on pins at tick t+LAT.
//  In HOLD, pipeline keeps shifting inactive/blank entries; outputs settle to blank, syncs inactive.
//  frame_start: pulses for one clk with the pix_en that wraps to (0,0) in RUN; not repeated during HOLD;
//   no pulse at reset release. Same clk: frame_cnt+1 (0xFFFF -> 0), ch_shadow <= ch_in.
//  ch_in changing on any other cycle does not affect ch_shadow.
// CONFIGURATION
//  VGA_TESTPAT_EN defined: when test_mode=1, the pipeline's RGB source is 8 vertical bars of width H_VA/8 by delayed hcnt
//   (white,yellow,cyan,green,magenta,red,blue,black); rgb_in ignored; timing unchanged.
//  Not defined: test_mode ignored, RGB always from rgb_in; no bar logic synthesised.
// TESTING
//  1 Defaults, rst released, stop=0: hs low exactly 96 px (192 clk) per 1600-clk line; vs low 2 lines; frame 840000 clk.
//  2 rgb_in=24'h123456 constant: R/G/B=12/34/56 only while blank_n=1; first visible pixel appears LAT=2 pix ticks after (x,y)=(0,0).
//  3 ch_in changed at line 100 from 10 to 250: ch_shadow stays 10 until frame_start, then 250; frame_cnt 0->1.
//  4 stop=1 at line 200: scan continues to frame end, holds (0,0), no further frame_start; stop=0 resumes, next pulse after 840000 clk.
//  5 rst low at hcnt=300,vcnt=50: all outputs at reset values in same cycle; after release, x,y restart from 0,0.
//  6 CLK_DIV=1, LAT=3, HS_POL=1 (VGA_TESTPAT_EN, test_mode=1): hs high 96 clk/line; pixel 0 = FFFFFF, pixel 80 = FFFF00.

Source files
------------

// File: rtl/vga_timing_engine_if.sv
// Renderer link of vga_timing_engine: request coordinate and pixel strobe out,
// renderer colour back.
interface vga_timing_engine_if;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        req_active;
    logic [23:0] rgb_in;

    modport master (output pix_en, output x, output y, output req_active, input rgb_in);
    modport slave  (input pix_en, input x, input y, input req_active, output rgb_in);
endinterface

// File: rtl/vga_timing_engine.sv
// VGA timing engine: pixel divider, H/V scan with RUN/HOLD, latency-matched sync/blank/RGB
// pipeline and frame-latched state channels. Define VGA_TESTPAT_EN for the colour-bar source.
module vga_timing_engine #(
    parameter int H_VA    = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VA    = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CLK_DIV = 2,
    parameter int LAT     = 2,
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stop,
    input  logic                     test_mode,
    input  logic [NUM_CH*DATA_W-1:0] ch_in,
    vga_timing_engine_if.master      ren,
    output logic                     hs,
    output logic                     vs,
    output logic                     blank_n,
    output logic                     sync_n,
    output logic [7:0]               R,
    output logic [7:0]               G,
    output logic [7:0]               B,
    output logic                     frame_start,
    output logic [15:0]              frame_cnt,
    output logic [NUM_CH*DATA_W-1:0] ch_shadow
);

    localparam int H_TOTAL  = H_VA + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VA + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VA + H_FP;
    localparam int HS_END   = H_VA + H_FP + H_SYNC;
    localparam int VS_START = V_VA + V_FP;
    localparam int VS_END   = V_VA + V_FP + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [9:0]       hcnt;
    logic [9:0]       vcnt;
    logic [0:0]       state;
    logic             h_end;
    logic             v_end;
    logic             frame_wrap;
    logic             active_raw;
    logic             hs_on;
    logic             vs_on;
    logic             hs_raw;
    logic             vs_raw;
    logic [LAT-1:0]   hs_pipe;
    logic [LAT-1:0]   vs_pipe;
    logic [LAT-1:0]   act_pipe;
    logic [LAT-1:0]   hs_next;
    logic [LAT-1:0]   vs_next;
    logic [LAT-1:0]   act_next;
    logic [23:0]      src_rgb;
    logic [23:0]      rgb_q;

    assign pix_en = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign h_end      = (hcnt == 10'(H_TOTAL - 1));
    assign v_end      = (vcnt == 10'(V_TOTAL - 1));
    assign frame_wrap = pix_en && (state == RUN) && h_end && v_end;

    // HOLD parks the scan at (0,0); the pix_en that clears stop only re-arms RUN,
    // so (0,0) is issued for a full tick before the scan moves on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt  <= '0;
            vcnt  <= '0;
            state <= RUN;
        end else if (pix_en) begin
            if (state == HOLD) begin
                if (!stop) begin
                    state <= RUN;
                end
            end else if (h_end) begin
                hcnt <= '0;
                if (v_end) begin
                    vcnt <= '0;
                    if (stop) begin
                        state <= HOLD;
                    end
                end else begin
                    vcnt <= vcnt + 10'd1;
                end
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            ch_shadow   <= '0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
                ch_shadow <= ch_in;
            end
        end
    end

    always_comb begin
        active_raw = 1'b0;
        hs_on      = 1'b0;
        vs_on      = 1'b0;
        if (state == RUN) begin
            active_raw = (int'(hcnt) < H_VA) && (int'(vcnt) < V_VA);
            hs_on      = (int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END);
            vs_on      = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END);
        end
    end

    assign hs_raw   = hs_on ? HS_POL : ~HS_POL;
    assign vs_raw   = vs_on ? VS_POL : ~VS_POL;
    assign hs_next  = LAT'({hs_pipe, hs_raw});
    assign vs_next  = LAT'({vs_pipe, vs_raw});
    assign act_next = LAT'({act_pipe, active_raw});

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W = (H_VA / 8 > 0) ? H_VA / 8 : 1;

    logic [2:0]       bar_raw;
    logic [3*LAT-1:0] bar_pipe;
    logic [3*LAT-1:0] bar_next;
    logic [2:0]       bar;
    logic [2:0]       unused_bar_tail;

    always_comb begin
        bar_raw = 3'd7;
        if (int'(hcnt) < 8 * BAR_W) begin
            bar_raw = 3'(int'(hcnt) / BAR_W);
        end
    end

    assign bar_next        = (3*LAT)'({bar_pipe, bar_raw});
    assign bar             = bar_next[3*LAT-1 -: 3];
    assign unused_bar_tail = bar_pipe[3*LAT-1 -: 3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_pipe <= '0;
        end else if (pix_en) begin
            bar_pipe <= bar_next;
        end
    end

    // Bar index order white..black maps to inverted {G,R,B} bits of the index.
    assign src_rgb = test_mode ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : ren.rgb_in;
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign src_rgb          = ren.rgb_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_pipe  <= {LAT{~HS_POL}};
            vs_pipe  <= {LAT{~VS_POL}};
            act_pipe <= '0;
            rgb_q    <= '0;
        end else if (pix_en) begin
            hs_pipe  <= hs_next;
            vs_pipe  <= vs_next;
            act_pipe <= act_next;
            rgb_q    <= act_next[LAT-1] ? src_rgb : '0;
        end
    end

    assign hs      = hs_pipe[LAT-1];
    assign vs      = vs_pipe[LAT-1];
    assign blank_n = act_pipe[LAT-1];
    assign sync_n  = 1'b1;
    assign R       = rgb_q[23:16];
    assign G       = rgb_q[15:8];
    assign B       = rgb_q[7:0];

    assign ren.pix_en     = pix_en;
    assign ren.x          = hcnt;
    assign ren.y          = vcnt;
    assign ren.req_active = active_raw;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine: small-geometry instance A, fast test-pattern instance B
// and a default-parameter instance C for real 640x480 line timing.
module tb_vga_timing_engine;

    localparam logic [39:0] CH0 = {10'd40, 10'd30, 10'd20, 10'd10};
    localparam logic [39:0] CH1 = {10'd40, 10'd30, 10'd20, 10'd250};
`ifdef VGA_TESTPAT_EN
    localparam logic [23:0] EXP_P0 = 24'hFFFFFF;
    localparam logic [23:0] EXP_P2 = 24'hFFFF00;
    localparam logic [23:0] EXP_P4 = 24'h00FFFF;
`else
    localparam logic [23:0] EXP_P0 = 24'hA5C33C;
    localparam logic [23:0] EXP_P2 = 24'hA5C33C;
    localparam logic [23:0] EXP_P4 = 24'hA5C33C;
`endif

    logic clk = 1'b0;
    logic rst_a, rst_o;
    logic stop_a, stop_b, stop_c;
    logic tm_a, tm_b, tm_c;
    logic [39:0] ch_a, ch_b, ch_c;

    logic hs_a, vs_a, blank_a, sync_a, fs_a;
    logic [7:0] r_a, g_a, b_a;
    logic [15:0] fcnt_a;
    logic [39:0] sh_a;

    logic hs_b, blank_b;
    logic [7:0] r_b, g_b, b_b;
    logic b_unused_vs, b_unused_sync, b_unused_fs;
    logic [15:0] b_unused_fcnt;
    logic [39:0] b_unused_sh;

    logic hs_c;
    logic c_unused_vs, c_unused_blank, c_unused_sync, c_unused_fs;
    logic [7:0] c_unused_r, c_unused_g, c_unused_b;
    logic [15:0] c_unused_fcnt;
    logic [39:0] c_unused_sh;

    int n_vec = 0;
    int n_err = 0;
    int viol  = 0;

    vga_timing_engine_if ia();
    vga_timing_engine_if ib();
    vga_timing_engine_if ic();

    always #5 clk = ~clk;

    vga_timing_engine #(
        .H_VA(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VA(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .stop(stop_a), .test_mode(tm_a), .ch_in(ch_a), .ren(ia),
        .hs(hs_a), .vs(vs_a), .blank_n(blank_a), .sync_n(sync_a), .R(r_a), .G(g_a), .B(b_a),
        .frame_start(fs_a), .frame_cnt(fcnt_a), .ch_shadow(sh_a)
    );

    vga_timing_engine #(
        .H_VA(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VA(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .LAT(3), .HS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_o), .stop(stop_b), .test_mode(tm_b), .ch_in(ch_b), .ren(ib),
        .hs(hs_b), .vs(b_unused_vs), .blank_n(blank_b), .sync_n(b_unused_sync),
        .R(r_b), .G(g_b), .B(b_b), .frame_start(b_unused_fs), .frame_cnt(b_unused_fcnt),
        .ch_shadow(b_unused_sh)
    );

    vga_timing_engine dut_c (
        .clk(clk), .rst(rst_o), .stop(stop_c), .test_mode(tm_c), .ch_in(ch_c), .ren(ic),
        .hs(hs_c), .vs(c_unused_vs), .blank_n(c_unused_blank), .sync_n(c_unused_sync),
        .R(c_unused_r), .G(c_unused_g), .B(c_unused_b), .frame_start(c_unused_fs),
        .frame_cnt(c_unused_fcnt), .ch_shadow(c_unused_sh)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return hs_c;
            1:       return hs_b;
            2:       return blank_b;
            3:       return hs_a;
            4:       return vs_a;
            default: return blank_a;
        endcase
    endfunction

    task automatic count_run(input int sel, input logic lvl, output int n);
        n = 0;
        while (probe(sel) === lvl && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // length in clk of the next complete run at level lvl
    task automatic run_len(input int sel, input logic lvl, output int n);
        count_run(sel, lvl, n);
        count_run(sel, ~lvl, n);
        count_run(sel, lvl, n);
    endtask

    task automatic wait_xy_a(input int xx, input int yy);
        int n = 0;
        while (!(ia.x == 10'(xx) && ia.y == 10'(yy)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("wait_xy_a_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_fs_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs_a !== 1'b1 && n < 2000);
    endtask

    always @(negedge clk) begin
        if (rst_a) begin
            if (!blank_a && {r_a, g_a, b_a} != 24'h0) viol++;
            if (ia.x >= 10'd24 || ia.y >= 10'd10) viol++;
        end
        if (rst_o) begin
            if (!blank_b && {r_b, g_b, b_b} != 24'h0) viol++;
            if (ib.x >= 10'd24 || ib.y >= 10'd10) viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int extra;
        rst_a = 1'b0; rst_o = 1'b0;
        stop_a = 1'b0; stop_b = 1'b0; stop_c = 1'b0;
        tm_a = 1'b0; tm_b = 1'b1; tm_c = 1'b0;
        ch_a = CH0; ch_b = '0; ch_c = '0;
        ia.rgb_in = 24'h123456;
        ib.rgb_in = 24'hA5C33C;
        ic.rgb_in = 24'h0;
        repeat (3) @(negedge clk);

        check("rst_x", ia.x, 0);
        check("rst_y", ia.y, 0);
        check("rst_hs", hs_a, 1);
        check("rst_vs", vs_a, 1);
        check("rst_blank", blank_a, 0);
        check("rst_rgb", {r_a, g_a, b_a}, 0);
        check("rst_fs", fs_a, 0);
        check("rst_fcnt", fcnt_a, 0);
        check("rst_shadow", sh_a, 0);
        check("sync_n", sync_a, 1);
        check("rst_pix_en_div2", ia.pix_en, 0);
        check("rst_hs_b_pol1", hs_b, 0);
        check("pix_en_div1", ib.pix_en, 1);

        rst_o = 1'b1;
        run_len(0, 1'b0, n);
        check("c_hs_low_clk", n, 192);
        count_run(0, 1'b1, n);
        check("c_hs_high_clk", n, 1408);

        run_len(1, 1'b1, n);
        check("b_hs_high_clk", n, 4);
        count_run(1, 1'b0, n);
        check("b_hs_low_clk", n, 20);
        n = 0;
        while (!(ib.x == 10'd0 && ib.y == 10'd1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (blank_b !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_first_px_lat", n, 3);
        check("b_px0", {r_b, g_b, b_b}, EXP_P0);
        repeat (2) @(negedge clk);
        check("b_px2", {r_b, g_b, b_b}, EXP_P2);
        repeat (2) @(negedge clk);
        check("b_px4", {r_b, g_b, b_b}, EXP_P4);
        count_run(2, 1'b1, n);
        check("b_visible_rest", n, 12);

        @(negedge clk);
        rst_a = 1'b1;
        wait_xy_a(0, 3);
        check("a_shadow_pre", sh_a, 0);
        check("a_fcnt_pre", fcnt_a, 0);
        run_len(3, 1'b0, n);
        check("a_hs_low_clk", n, 8);
        count_run(3, 1'b1, n);
        check("a_hs_high_clk", n, 40);

        wait_fs_a(n);
        check("a_fs_seen", fs_a, 1);
        check("a_fcnt_1", fcnt_a, 1);
        check("a_shadow_1", sh_a, CH0);
        check("a_wrap_xy", {ia.x, ia.y}, 0);
        check("a_wrap_blank", blank_a, 0);
        check("a_wrap_rgb", {r_a, g_a, b_a}, 0);
        n = 1;
        @(negedge clk);
        check("a_fs_one_clk", fs_a, 0);
        while (blank_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_first_px_lat", n, 4);
        check("a_px0_rgb", {r_a, g_a, b_a}, 24'h123456);
        count_run(5, 1'b1, n);
        check("a_visible_clk", n, 32);
        run_len(4, 1'b0, n);
        check("a_vs_low_clk", n, 96);

        wait_xy_a(0, 3);
        ch_a = CH1;
        wait_xy_a(0, 5);
        check("a_shadow_hold", sh_a, CH0);
        check("a_fcnt_2", fcnt_a, 2);
        wait_fs_a(n);
        check("a_shadow_new", sh_a, CH1);
        check("a_fcnt_3", fcnt_a, 3);
        wait_fs_a(n);
        check("a_frame_clk", n, 480);
        check("a_fcnt_4", fcnt_a, 4);

        wait_xy_a(0, 4);
        stop_a = 1'b1;
        wait_fs_a(n);
        check("a_stop_frame_ends", fs_a, 1);
        check("a_fcnt_5", fcnt_a, 5);
        extra = 0;
        repeat (1500) begin
            @(negedge clk);
            if (fs_a) extra++;
        end
        check("a_hold_no_fs", extra, 0);
        check("a_hold_xy", {ia.x, ia.y}, 0);
        check("a_hold_blank", blank_a, 0);
        check("a_hold_hs", hs_a, 1);
        check("a_hold_vs", vs_a, 1);
        check("a_hold_fcnt", fcnt_a, 5);
        n = 0;
        while (ia.pix_en !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        stop_a = 1'b0;
        wait_fs_a(n);
        check("a_resume_clk", n, 481);
        check("a_fcnt_6", fcnt_a, 6);

        wait_xy_a(10, 2);
        check("a_mid_visible", blank_a, 1);
        rst_a = 1'b0;
        #1;
        check("a_mrst_xy", {ia.x, ia.y}, 0);
        check("a_mrst_blank", blank_a, 0);
        check("a_mrst_hs", hs_a, 1);
        check("a_mrst_rgb", {r_a, g_a, b_a}, 0);
        check("a_mrst_fcnt", fcnt_a, 0);
        check("a_mrst_shadow", sh_a, 0);
        @(negedge clk);
        rst_a = 1'b1;
        extra = 0;
        n = 0;
        while (ia.x == 10'd0 && n < 10) begin
            @(negedge clk);
            n++;
            if (fs_a) extra++;
        end
        check("a_restart_xy", {ia.x, ia.y}, {10'd1, 10'd0});
        check("a_no_fs_at_release", extra, 0);

        check("invariants", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
